// File: rtl/mux4_pkg.sv
// Shared types and select encodings for the 4-source arbitrated mux.
package mux4_pkg;

    localparam int unsigned SRC_N = 4;
    localparam int unsigned IDX_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Downstream mux select, packed as {con1, con2}
    typedef logic [1:0] sel_t;

    localparam sel_t SEL_SRC0 = 2'b00;
    localparam sel_t SEL_SRC1 = 2'b11;
    localparam sel_t SEL_SRC2 = 2'b10;
    localparam sel_t SEL_SRC3 = 2'b01;

    // Map a source index to its {con1, con2} select pair
    function automatic sel_t sel_of(input logic [IDX_W-1:0] idx);
        sel_t sel;
        case (idx)
            2'd0:    sel = SEL_SRC0;
            2'd1:    sel = SEL_SRC1;
            2'd2:    sel = SEL_SRC2;
            default: sel = SEL_SRC3;
        endcase
        return sel;
    endfunction

    // One-hot grant vector for a source index
    function automatic logic [SRC_N-1:0] onehot4(input logic [IDX_W-1:0] idx);
        return SRC_N'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first requester above 'last', skipping excluded sources.
module rr_pick4
    import mux4_pkg::*;
(
    input  logic [SRC_N-1:0] req,
    input  logic [IDX_W-1:0] last,
    input  logic [SRC_N-1:0] exclude,
    output logic [IDX_W-1:0] winner_c,
    output logic             found_c
);

    logic [SRC_N-1:0] cand;
    logic [IDX_W-1:0] idx;

    // Scan upward from last+1, wrapping, so 'last' itself is checked last
    always_comb begin
        cand     = req & ~exclude;
        winner_c = '0;
        found_c  = 1'b0;
        idx      = '0;
        for (int unsigned k = 1; k <= SRC_N; k++) begin
            idx = IDX_W'(last + k);
            if (!found_c && cand[idx]) begin
                found_c  = 1'b1;
                winner_c = idx;
            end
        end
    end

endmodule

// File: rtl/mux4_arb.sv
// Round-robin arbiter driving a downstream 4:1 mux, with bounded bursts per grant.
module mux4_arb
    import mux4_pkg::*;
#(
    parameter int unsigned MAX_BEATS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SRC_N-1:0] req,
    input  logic             ready,
    output logic [SRC_N-1:0] gnt,
    output logic             con1,
    output logic             con2,
    output logic             valid
);

    localparam int unsigned CNT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BEATS - 1);

    state_t           state;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] last_owner;
    logic [CNT_W-1:0] beat_cnt;

    logic [IDX_W-1:0] pick_last_c;
    logic [SRC_N-1:0] pick_excl_c;
    logic [IDX_W-1:0] winner_c;
    logic             found_c;
    logic             beat_c;
    logic             release_c;

    // Picker inputs: fresh arbitration from IDLE, or hand-off excluding the current owner
    always_comb begin
        pick_last_c = last_owner;
        pick_excl_c = '0;
        if (state == GRANT) begin
            pick_last_c = owner;
            pick_excl_c = onehot4(owner);
        end
        beat_c    = valid & ready;
        release_c = (state == GRANT) &&
                    ((beat_c && (beat_cnt == LAST_BEAT)) || !req[owner]);
    end

    rr_pick4 u_pick (
        .req      (req),
        .last     (pick_last_c),
        .exclude  (pick_excl_c),
        .winner_c (winner_c),
        .found_c  (found_c)
    );

    // Arbitration state machine with registered grant/select/valid outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 2'd3;
            last_owner <= 2'd3;
            beat_cnt   <= '0;
            gnt        <= '0;
            con1       <= 1'b0;
            con2       <= 1'b0;
            valid      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found_c) begin
                        state        <= GRANT;
                        owner        <= winner_c;
                        beat_cnt     <= '0;
                        gnt          <= onehot4(winner_c);
                        {con1, con2} <= sel_of(winner_c);
                        valid        <= 1'b1;
                    end
                end
                GRANT: begin
                    if (release_c) begin
                        last_owner <= owner;
                        beat_cnt   <= '0;
                        if (found_c) begin
                            owner        <= winner_c;
                            gnt          <= onehot4(winner_c);
                            {con1, con2} <= sel_of(winner_c);
                            valid        <= 1'b1;
                        end else begin
                            state        <= IDLE;
                            gnt          <= '0;
                            {con1, con2} <= 2'b00;
                            valid        <= 1'b0;
                        end
                    end else if (beat_c) begin
                        beat_cnt <= CNT_W'(beat_cnt + 1'b1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux4_arb.sv
// Bench for mux4_arb: two instances (MAX_BEATS 4 and 1) fed the same stimulus,
// scoreboarded against a cycle model, plus directed scenario checks.
module tb_mux4_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       ready;

    logic [3:0] gnt4, gnt1;
    logic       con1_4, con2_4, valid4;
    logic       con1_1, con2_1, valid1;
    logic [6:0] o4, o1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign o4 = {gnt4, con1_4, con2_4, valid4};
    assign o1 = {gnt1, con1_1, con2_1, valid1};

    mux4_arb #(.MAX_BEATS(4)) dut4 (
        .clk(clk), .rst(rst), .req(req), .ready(ready),
        .gnt(gnt4), .con1(con1_4), .con2(con2_4), .valid(valid4)
    );

    mux4_arb #(.MAX_BEATS(1)) dut1 (
        .clk(clk), .rst(rst), .req(req), .ready(ready),
        .gnt(gnt1), .con1(con1_1), .con2(con2_1), .valid(valid1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model state, index 0 = MAX_BEATS 4, index 1 = MAX_BEATS 1
    int m_busy [2];
    int m_own  [2];
    int m_last [2];
    int m_cnt  [2];
    int mb     [2];

    logic [6:0] exp_q0 [$];
    logic [6:0] exp_q1 [$];

    function automatic logic [1:0] cc_of(input int s);
        case (s)
            0:       return 2'b00;
            1:       return 2'b11;
            2:       return 2'b10;
            default: return 2'b01;
        endcase
    endfunction

    task automatic model_step(input int d, input logic r, input logic [3:0] q, input logic rd);
        int  cand;
        bit  done;
        if (r) begin
            m_busy[d] = 0;
            m_last[d] = 3;
            m_cnt[d]  = 0;
            m_own[d]  = 0;
        end else if (m_busy[d] == 0) begin
            for (int k = 1; k <= 4; k++) begin
                cand = (m_last[d] + k) % 4;
                if (m_busy[d] == 0 && q[2'(cand)]) begin
                    m_busy[d] = 1;
                    m_own[d]  = cand;
                    m_cnt[d]  = 0;
                end
            end
        end else begin
            done = (rd && (m_cnt[d] == mb[d] - 1)) || !q[2'(m_own[d])];
            if (!done) begin
                if (rd) m_cnt[d]++;
            end else begin
                m_last[d] = m_own[d];
                m_busy[d] = 0;
                m_cnt[d]  = 0;
                for (int k = 1; k <= 3; k++) begin
                    cand = (m_last[d] + k) % 4;
                    if (m_busy[d] == 0 && q[2'(cand)]) begin
                        m_busy[d] = 1;
                        m_own[d]  = cand;
                    end
                end
            end
        end
    endtask

    function automatic logic [6:0] model_out(input int d);
        logic [3:0] g;
        if (m_busy[d] == 0) return 7'b0;
        g = 4'b0001 << m_own[d];
        return {g, cc_of(m_own[d]), 1'b1};
    endfunction

    // Drive one cycle: push model expectations, clock, then pop and compare both instances
    task automatic step(input logic r, input logic [3:0] q, input logic rd);
        rst   = r;
        req   = q;
        ready = rd;
        model_step(0, r, q, rd);
        model_step(1, r, q, rd);
        exp_q0.push_back(model_out(0));
        exp_q1.push_back(model_out(1));
        @(posedge clk);
        #1;
        chk("sb_mb4", 32'(o4), 32'(exp_q0.pop_front()));
        chk("sb_mb1", 32'(o1), 32'(exp_q1.pop_front()));
    endtask

    logic [3:0] rot_g [5];
    logic [1:0] rot_c [5];

    initial begin
        mb[0] = 4;
        mb[1] = 1;
        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 0; m_own[d] = 0; m_last[d] = 3; m_cnt[d] = 0;
        end
        rot_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rot_c = '{2'b00, 2'b11, 2'b10, 2'b01, 2'b00};

        // Reset with all sources requesting, then first grant goes to source 0
        step(1'b1, 4'hF, 1'b1);
        step(1'b1, 4'hF, 1'b1);
        chk("rst_out4", 32'(o4), 32'(7'b0));
        chk("rst_out1", 32'(o1), 32'(7'b0));
        step(1'b0, 4'hF, 1'b0);
        chk("first_gnt", 32'(o4), 32'({4'b0001, 2'b00, 1'b1}));

        // Backpressure on source 1: nothing moves and no beats are counted
        step(1'b1, 4'hF, 1'b0);
        step(1'b0, 4'b0010, 1'b0);
        chk("bp_gnt", 32'(o4), 32'({4'b0010, 2'b11, 1'b1}));
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'hF, 1'b0);
            chk("bp_hold", 32'(o4), 32'({4'b0010, 2'b11, 1'b1}));
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'hF, 1'b1);
            chk("bp_beat", 32'(o4), 32'({4'b0010, 2'b11, 1'b1}));
        end
        step(1'b0, 4'hF, 1'b1);
        chk("bp_release", 32'(o4), 32'({4'b0100, 2'b10, 1'b1}));

        // Single-beat rotation across all four sources
        step(1'b1, 4'hF, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'hF, 1'b1);
            chk("rot_gnt", 32'({gnt1, con1_1, con2_1}), 32'({rot_g[i], rot_c[i]}));
        end

        // Burst limit with a lone requester: 4 beats, one idle cycle, 4 beats
        step(1'b1, 4'b0100, 1'b1);
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 4; i++) begin
                step(1'b0, 4'b0100, 1'b1);
                chk("burst_gnt", 32'({gnt4, valid4}), 32'(5'b01001));
            end
            step(1'b0, 4'b0100, 1'b1);
            chk("burst_idle", 32'({gnt4, valid4}), 32'(5'b00000));
        end

        // Early drop of source 3 hands straight to source 0 with no bubble
        step(1'b1, 4'hF, 1'b0);
        step(1'b0, 4'b1000, 1'b1);
        chk("drop_gnt3", 32'(o4), 32'({4'b1000, 2'b01, 1'b1}));
        step(1'b0, 4'b1001, 1'b1);
        chk("drop_hold", 32'(o4), 32'({4'b1000, 2'b01, 1'b1}));
        step(1'b0, 4'b0001, 1'b1);
        chk("drop_next", 32'(o4), 32'({4'b0001, 2'b00, 1'b1}));

        // Reset during the second beat of a burst
        step(1'b1, 4'hF, 1'b0);
        step(1'b0, 4'hF, 1'b1);
        step(1'b0, 4'hF, 1'b1);
        step(1'b1, 4'hF, 1'b1);
        chk("midrst_out", 32'(o4), 32'(7'b0));
        step(1'b0, 4'hF, 1'b1);
        chk("midrst_regnt", 32'(o4), 32'({4'b0001, 2'b00, 1'b1}));

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 39) == 0), 4'($urandom), 1'($urandom_range(0, 3) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux4_arb.md
MUX4_ARB -- requirements
Module: mux4_arb

Interface
REQ-001 SHALL have parameter MAX_BEATS, default 4, giving the maximum beats per grant (legal range 1..16).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port req, input, 4 bits: level request per source; bit 0 is the i1 source, bit 1 i2, bit 2 i3, bit 3 i4.
REQ-005 SHALL have port ready, input, 1 bit: downstream accepts the current beat.
REQ-006 SHALL have port gnt, output, 4 bits: one-hot grant, or 0 when idle.
REQ-007 SHALL have port con1, output, 1 bit: select bit 1 to the downstream 4:1 mux.
REQ-008 SHALL have port con2, output, 1 bit: select bit 2 to the downstream 4:1 mux.
REQ-009 SHALL have port valid, output, 1 bit: a beat from the granted source is presented this cycle.

Function
REQ-010 SHALL implement two states: IDLE and GRANT.
REQ-011 SHALL drive all outputs from registers, with no combinational path from req/ready to any output.
REQ-012 SHALL encode con1/con2 as: source 0 = 0/0, source 1 = 1/1, source 2 = 1/0, source 3 = 0/1.
REQ-013 SHALL drive, in IDLE: gnt=0000, valid=0, con1=0, con2=0.
REQ-014 SHALL, in IDLE with req!=0, enter GRANT the next cycle with the winner's gnt bit set, matching con1/con2, valid=1 and beat count 0.
REQ-015 SHALL choose the winner round-robin, searching upward (modulo 4) from last_owner+1; last_owner resets to 3, so source 0 has first priority after reset.
REQ-016 SHALL count a beat when valid && ready; a beat increments the beat counter, which is log2-sized to hold MAX_BEATS-1.
REQ-017 SHALL release the grant when, in GRANT, either (a) a beat occurs and the beat count equals MAX_BEATS-1, or (b) req[owner] is sampled low; case (b) with ready high still counts the beat.
REQ-018 SHALL, on release, record the owner as last_owner and re-arbitrate in the same cycle over req excluding the current owner; with a winner present, GRANT continues next cycle with the new owner (no bubble), otherwise the block returns to IDLE.
REQ-019 SHALL re-grant the just-released owner only when no other source requests; it then passes through IDLE for one cycle first.
REQ-020 SHALL keep gnt, con1, con2 and the owner stable while valid=1 and ready=0 (no beat), regardless of other req changes.
REQ-021 SHALL, with MAX_BEATS=1, release the grant after every beat.

Reset
REQ-022 SHALL, with rst high at a clock edge, force state=IDLE, gnt=0000, valid=0, con1=0, con2=0, beat count=0 and last_owner=3, overriding any simultaneous req/ready.
REQ-023 SHALL abort a reset asserted mid-grant without counting the cycle's beat, and arbitrate normally starting the first cycle after rst falls.

Structure
REQ-024 SHALL place the state enum (IDLE, GRANT) and the four 2-bit select encodings (con1, con2 per source) in shared package mux4_pkg, reused by the mux and its benches.
REQ-025 SHALL contain one sub-module, rr_pick4: combinational round-robin picker with inputs req[3:0], last[1:0] and exclude mask; outputs winner index and found flag.

Verification
REQ-026 SHALL cover reset: rst=1 for 2 cycles with req=1111 -> gnt=0000, valid=0, con1/con2=0/0; after release, the first grant is gnt=0001, con1/con2=0/0.
REQ-027 SHALL cover rotation: req=1111, ready=1, MAX_BEATS=1 -> gnt sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles, and con1/con2 sequence 00, 11, 10, 01, 00.
REQ-028 SHALL cover burst limit: req=0100 held, ready=1, MAX_BEATS=4 -> 4 beats with gnt=0100, one IDLE cycle, then 4 more beats.
REQ-029 SHALL cover backpressure: source 1 granted, ready=0 for 5 cycles while req=1111 -> gnt=0010, valid=1 and con1/con2=1/1 unchanged, with no beats counted.
REQ-030 SHALL cover early drop: source 3 granted, req[3] falls after 1 beat with req[0]=1 -> the next cycle gnt=0001, valid=1, with no idle cycle.
REQ-031 SHALL cover mid-grant reset: rst pulsed during beat 2 of a burst -> the next cycle is IDLE with all outputs 0 and last_owner=3.
